mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 27 ++
 rtl/rr_arbiter2.sv | 27 ++
 rtl/mem_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared FSM states, access-size codes and error decode for mem_ctrl
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    // Misaligned halves/words and the unused codes 011/110/111 are rejected.
    function automatic logic size_err(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            SZ_B, SZ_BU: size_err = 1'b0;
            SZ_H, SZ_HU: size_err = lo[0];
            SZ_W:        size_err = (lo != 2'b00);
            default:     size_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with a tie-break pointer
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // prio names the requester that wins when both are asking
    logic prio;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
            else              gnt = req;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)       prio <= 1'b0;
        else if (gnt[0]) prio <= 1'b1;
        else if (gnt[1]) prio <= 1'b0;
    end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - two-requester RAM access controller with sub-word load/store handling
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 17
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            req_i,
    input  logic [1:0]            we_i,
    input  logic [1:0][2:0]       size_i,
    input  logic [1:0][WIDTH-1:0] addr_i,
    input  logic [1:0][WIDTH-1:0] wdata_i,
    output logic [1:0]            gnt_o,
    output logic [1:0]            rvalid_o,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  err_o,
    output logic                  ram_we_o,
    output logic [WIDTH-1:0]      ram_a_o,
    output logic [WIDTH-1:0]      ram_wd_o,
    input  logic [WIDTH-1:0]      ram_rd_i
);

    state_t                 state, state_n;
    logic                   sel, k_q, we_q, err_q;
    logic [2:0]             size_q;
    logic [ADDR_BITS-1:0]   addr_q, aligned;
    logic [WIDTH-1:0]       wdata_q, word_q;
    logic [4:0]             shift;
    logic [WIDTH-1:0]       lane, loaded, mask, merged;
    logic                   arb_en, acc_err, we_raw, rvalid_raw;
    logic                   unused_addr_hi;

    assign unused_addr_hi = ^{addr_i[0][WIDTH-1:ADDR_BITS], addr_i[1][WIDTH-1:ADDR_BITS]};

    assign arb_en = (state == IDLE) && !rst_i;

    rr_arbiter2 u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req   (req_i),
        .en    (arb_en),
        .gnt   (gnt_o)
    );

    assign sel     = gnt_o[1];
    assign aligned = {addr_q[ADDR_BITS-1:2], 2'b00};
    assign shift   = {addr_q[1:0], 3'b000};
    assign lane    = ram_rd_i >> shift;
    assign acc_err = size_err(size_q, addr_q[1:0]);

    always_comb begin
        case (size_q)
            SZ_B:    loaded = {{(WIDTH-8){lane[7]}}, lane[7:0]};
            SZ_BU:   loaded = {{(WIDTH-8){1'b0}}, lane[7:0]};
            SZ_H:    loaded = {{(WIDTH-16){lane[15]}}, lane[15:0]};
            SZ_HU:   loaded = {{(WIDTH-16){1'b0}}, lane[15:0]};
            default: loaded = lane;
        endcase
    end

    // Read-modify-write: keep the untouched lanes of the current RAM word
    assign mask   = size_q[0] ? WIDTH'(16'hFFFF) : WIDTH'(8'hFF);
    assign merged = (ram_rd_i & ~(mask << shift)) | ((wdata_q & mask) << shift);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            k_q     <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && gnt_o != 2'b00) begin
                k_q     <= sel;
                we_q    <= we_i[sel];
                size_q  <= size_i[sel];
                addr_q  <= addr_i[sel][ADDR_BITS-1:0];
                wdata_q <= wdata_i[sel];
            end
            if (state == ACCESS) begin
                word_q <= we_q ? merged : loaded;
                err_q  <= acc_err;
            end
        end
    end

    always_comb begin
        state_n    = state;
        we_raw     = 1'b0;
        rvalid_raw = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_o != 2'b00) state_n = ACCESS;
            end
            ACCESS: begin
                if (acc_err || !we_q) begin
                    state_n = RESP;
                end else if (size_q == SZ_W) begin
                    we_raw  = 1'b1;
                    state_n = RESP;
                end else begin
                    state_n = WRITE;
                end
            end
            WRITE: begin
                we_raw  = 1'b1;
                state_n = RESP;
            end
            RESP: begin
                rvalid_raw = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Reset squashes any write or completion in the cycle it is asserted
    always_comb begin
        ram_we_o = we_raw && !rst_i;
        rvalid_o = 2'b00;
        rdata_o  = '0;
        err_o    = 1'b0;
        if (rvalid_raw && !rst_i) begin
            rvalid_o[k_q] = 1'b1;
            err_o         = err_q;
            if (!we_q && !err_q) rdata_o = word_q;
        end
        ram_a_o                  = '0;
        ram_a_o[ADDR_BITS-1:0]   = aligned;
        ram_wd_o = (state == WRITE) ? word_q : wdata_q;
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl with a byte-array memory model
module tb_mem_ctrl;

    localparam int W  = 32;
    localparam int AB = 17;
    localparam int NW = 1 << (AB - 2);

    typedef struct {
        int         k;
        logic       we;
        logic [2:0] sz;
        logic [W-1:0] a;
        logic [W-1:0] d;
        int         gcyc;
        int         webase;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic req0, req1, we0, we1;
    logic [2:0] sz0, sz1;
    logic [W-1:0] a0, a1, d0, d1;
    logic [1:0] gnt, rvalid;
    logic [W-1:0] rdata, ram_a, ram_wd, ram_rd;
    logic err, ram_we;

    mem_ctrl #(.WIDTH(W), .ADDR_BITS(AB)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    ({req1, req0}),
        .we_i     ({we1, we0}),
        .size_i   ({sz1, sz0}),
        .addr_i   ({a1, a0}),
        .wdata_i  ({d1, d0}),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .err_o    (err),
        .ram_we_o (ram_we),
        .ram_a_o  (ram_a),
        .ram_wd_o (ram_wd),
        .ram_rd_i (ram_rd)
    );

    logic [W-1:0] ram [NW];
    assign ram_rd = ram[ram_a[AB-1:2]];
    always @(posedge clk) if (ram_we) ram[ram_a[AB-1:2]] <= ram_wd;

    logic [7:0] mdl [1 << AB];
    txn_t q[$];
    int gnt_log[$];
    int ntests = 0, nfail = 0, cyc = 0, we_cnt = 0;
    bit busy = 0, prio = 0;
    logic [W-1:0] last_rd;
    logic last_err;
    int last_lat;

    always @(posedge clk) cyc++;

    task automatic chk(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        ntests++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model(input txn_t t, output logic [W-1:0] rd, output logic e,
                                  output int lat, output int nwe);
        int a, c, nb;
        logic [W-1:0] v, ones;
        a  = int'(t.a & 32'h1FFFF);
        c  = int'(t.sz);
        nb = (c % 4 == 0) ? 1 : (c % 4 == 1) ? 2 : 4;
        e  = (c == 3 || c == 6 || c == 7) || ((c == 1 || c == 5) && (a % 2 != 0)) || (c == 2 && a % 4 != 0);
        rd = '0; lat = 2; nwe = 0;
        if (e) return;
        if (t.we) begin
            nwe = 1;
            lat = (nb == 4) ? 2 : 3;
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v |= W'(mdl[a + i]) << (8 * i);
            ones = '1;
            if (c < 4 && nb < 4 && v[8 * nb - 1]) v |= ones << (8 * nb);
            rd = v;
        end
    endfunction

    task automatic commit(input txn_t t);
        int a, nb;
        a  = int'(t.a & 32'h1FFFF);
        nb = (t.sz[1:0] == 2'd0) ? 1 : (t.sz[1:0] == 2'd1) ? 2 : 4;
        if (t.we) for (int i = 0; i < nb; i++) mdl[a + i] = t.d[8 * i +: 8];
    endtask

    // Monitor: arbitration model, scoreboard push at grant, pop and compare at completion
    always @(negedge clk) begin
        logic [1:0] exp_g;
        txn_t t;
        logic [W-1:0] e_rd;
        logic e_err;
        int e_lat, e_nwe, win;
        if (ram_we) begin
            we_cnt++;
            chk(busy && !rst, "we_outside_txn", W'(ram_we), 32'h0);
        end
        if (rst) begin
            chk({gnt, rvalid, err, rdata} == '0, "reset_outputs", {rdata[W-6:0], gnt, rvalid, err}, 32'h0);
            q.delete();
            busy = 0;
            prio = 0;
        end else begin
            exp_g = 2'b00;
            if (!busy && {req1, req0} != 2'b00)
                exp_g = ({req1, req0} == 2'b11) ? (prio ? 2'b10 : 2'b01) : {req1, req0};
            if (exp_g != 2'b00 || gnt != 2'b00) begin
                chk(gnt == exp_g, "grant", W'(gnt), W'(exp_g));
                if (exp_g != 2'b00) begin
                    win = exp_g[1] ? 1 : 0;
                    t.k = win; t.gcyc = cyc; t.webase = we_cnt;
                    t.we = win ? we1 : we0;
                    t.sz = win ? sz1 : sz0;
                    t.a  = win ? a1 : a0;
                    t.d  = win ? d1 : d0;
                    q.push_back(t);
                    gnt_log.push_back(win);
                    busy = 1;
                    prio = (win == 0);
                end
            end
            if (rvalid != 2'b00) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_rvalid", W'(rvalid), 32'h0);
                end else begin
                    t = q.pop_front();
                    model(t, e_rd, e_err, e_lat, e_nwe);
                    chk(rvalid == (2'b01 << t.k), "rvalid_id", W'(rvalid), W'(2'b01 << t.k));
                    chk(rdata == e_rd, "rdata", rdata, e_rd);
                    chk(err == e_err, "err", W'(err), W'(e_err));
                    chk(cyc - t.gcyc == e_lat, "latency", W'(cyc - t.gcyc), W'(e_lat));
                    chk(we_cnt - t.webase == e_nwe, "ram_we_count", W'(we_cnt - t.webase), W'(e_nwe));
                    if (!e_err) commit(t);
                    last_rd = rdata; last_err = err; last_lat = cyc - t.gcyc;
                end
                busy = 0;
            end
        end
    end

    task automatic poke(input logic [W-1:0] a, input logic [W-1:0] v);
        int w;
        w = int'(a[AB-1:2]);
        ram[w] <= v;
        for (int b = 0; b < 4; b++) mdl[4 * w + b] = v[8 * b +: 8];
    endtask

    task automatic issue(input int k, input bit w, input logic [2:0] s, input logic [W-1:0] a,
                         input logic [W-1:0] d, input int gap);
        int n;
        repeat (gap) begin @(posedge clk); #1; end
        if (k == 0) begin req0 = 1; we0 = w; sz0 = s; a0 = a; d0 = d; end
        else        begin req1 = 1; we1 = w; sz1 = s; a1 = a; d1 = d; end
        n = 0;
        do begin @(negedge clk); n++; end while (!gnt[k] && n < 200);
        if (!gnt[k]) chk(1'b0, "gnt_timeout", W'(gnt), W'(2'b01 << k));
        @(posedge clk); #1;
        if (k == 0) req0 = 0; else req1 = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || q.size() != 0) && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk(1'b0, "drain_timeout", W'(q.size()), 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic rand_txn(input int k);
        logic [W-1:0] base, a;
        case ($urandom_range(0, 2))
            0:       base = 32'h10000;
            1:       base = 32'h1FFF0;
            default: base = 32'h00100;
        endcase
        a = (base + W'($urandom_range(0, 15))) | ($urandom & 32'hFFFE0000);
        issue(k, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, $urandom_range(0, 3));
    endtask

    initial begin
        logic [W-1:0] w;
        int bad;
        rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; sz0 = 0; sz1 = 0;
        a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        for (int i = 0; i < NW; i++) begin
            w = $urandom;
            ram[i] <= w;
            for (int b = 0; b < 4; b++) mdl[4 * i + b] = w[8 * b +: 8];
        end
        repeat (3) @(posedge clk);
        #1 rst = 0;

        poke(32'h10000, 32'hDEADBEEF);
        issue(0, 0, 3'b010, 32'h10000, 0, 1);
        drain();
        chk(last_rd == 32'hDEADBEEF && !last_err, "lw_deadbeef", last_rd, 32'hDEADBEEF);

        poke(32'h10000, 32'h11223344);
        issue(0, 1, 3'b000, 32'h10002, 32'h000000A5, 1);
        drain();
        chk(ram[32'h10000 >> 2] == 32'h11A53344, "sb_merge", ram[32'h10000 >> 2], 32'h11A53344);
        chk(last_lat == 3, "sb_latency", W'(last_lat), 32'd3);

        poke(32'h10000, 32'h80FFFFFF);
        issue(0, 0, 3'b000, 32'h10003, 0, 1);
        drain();
        chk(last_rd == 32'hFFFFFF80, "lb_sign", last_rd, 32'hFFFFFF80);
        issue(1, 0, 3'b100, 32'h10003, 0, 1);
        drain();
        chk(last_rd == 32'h00000080, "lbu_zero", last_rd, 32'h00000080);

        issue(0, 1, 3'b010, 32'h10001, 32'h12345678, 1);
        drain();
        chk(last_err == 1'b1, "sw_misaligned_err", W'(last_err), 32'h1);
        chk(ram[32'h10000 >> 2] == 32'h80FFFFFF, "sw_err_ram_kept", ram[32'h10000 >> 2], 32'h80FFFFFF);

        do_reset();
        gnt_log.delete();
        fork
            begin issue(0, 0, 3'b010, 32'h100, 0, 0); issue(0, 0, 3'b010, 32'h104, 0, 0); end
            begin issue(1, 0, 3'b010, 32'h108, 0, 0); issue(1, 0, 3'b010, 32'h10C, 0, 0); end
        join
        drain();
        chk(gnt_log.size() == 4 && gnt_log[0] == 0 && gnt_log[1] == 1 && gnt_log[2] == 0 && gnt_log[3] == 1,
            "rr_order", W'(gnt_log.size()), 32'd4);

        poke(32'h10000, 32'hCAFEF00D);
        @(posedge clk); #1;
        req0 = 1; we0 = 1; sz0 = 3'b001; a0 = 32'h10002; d0 = 32'h00001234;
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!gnt[0] && n < 50);
            chk(gnt[0] == 1'b1, "sh_grant", W'(gnt), 32'h1);
        end
        @(posedge clk); #1 req0 = 0;
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        chk(ram_we == 1'b0 && rvalid == 2'b00, "abort_no_write", W'({ram_we, rvalid}), 32'h0);
        @(posedge clk); #1 rst = 0;
        repeat (3) begin
            @(negedge clk);
            chk(ram_we == 1'b0 && rvalid == 2'b00, "abort_quiet", W'({ram_we, rvalid}), 32'h0);
        end
        chk(ram[32'h10000 >> 2] == 32'hCAFEF00D, "abort_ram_kept", ram[32'h10000 >> 2], 32'hCAFEF00D);
        @(posedge clk); #1;
        issue(0, 0, 3'b010, 32'h10000, 0, 0);
        drain();
        chk(last_rd == 32'hCAFEF00D, "lw_after_abort", last_rd, 32'hCAFEF00D);

        fork
            for (int i = 0; i < 60; i++) rand_txn(0);
            for (int j = 0; j < 60; j++) rand_txn(1);
        join
        drain();

        bad = 0;
        for (int i = 0; i < NW; i++)
            if (ram[i] != {mdl[4 * i + 3], mdl[4 * i + 2], mdl[4 * i + 1], mdl[4 * i]}) bad++;
        chk(bad == 0, "final_memory", W'(bad), 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0t expected <2000000", $time);
        $fatal(1, "timeout");
    end

endmodule
